reg_bank_scanner: RTL and testbench

- 16-entry by N-bit register bank with a timed channel sequencer.
- Drives the 16 data inputs and the 4-bit select of the downstream 16-to-1 multiplexer stage: q_flat slice k feeds mux input k; sel feeds the mux select.
- Loads entries through a single write port, then steps sel through the enabled channels.
- Holds each channel for a programmable dwell time.

---
 rtl/reg_bank_scanner.sv | 160 ++++++++++++++++
 tb/tb_reg_bank_scanner.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/reg_bank_scanner.sv
// 16-entry register bank feeding a 16:1 mux, with a dwell-timed channel sequencer driving the select.
// Optional SCAN_ONESHOT_EN: one pass over the enabled channels, then return to IDLE.
module reg_bank_scanner #(
    parameter int N     = 8,
    parameter int DWELL = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            wr_en,
    input  logic [3:0]      wr_addr,
    input  logic [N-1:0]    wr_data,
    input  logic            start,
    input  logic            stop,
    input  logic [15:0]     mask,
    output logic [16*N-1:0] q_flat,
    output logic [3:0]      sel,
    output logic            sel_valid,
    output logic            busy,
    output logic            wrap
);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_SCAN = 1'b1;
    localparam logic [7:0] DWELL_LAST = 8'(DWELL - 1);

    logic [N-1:0] bank_q [16];
    logic [0:0]   state_q, state_d;
    logic [3:0]   sel_q, sel_d;
    logic [7:0]   cnt_q, cnt_d;
    logic         wrap_q, wrap_d;
    logic         busy_q, busy_d;
    logic         valid_q, valid_d;
    logic [3:0]   next_s;

    // Lowest set bit of m (m assumed non-zero by callers).
    function automatic logic [3:0] lowest_chan(input logic [15:0] m);
        logic [3:0] res;
        res = 4'd0;
        for (int i = 15; i >= 0; i--) begin
            if (m[i]) begin
                res = 4'(i);
            end else begin
                res = res;
            end
        end
        return res;
    endfunction

    // First enabled channel above cur, wrapping; the last candidate is cur itself.
    function automatic logic [3:0] next_chan(input logic [15:0] m, input logic [3:0] cur);
        logic [3:0] res;
        logic [3:0] idx;
        logic       found;
        res   = cur;
        found = 1'b0;
        for (int i = 1; i <= 16; i++) begin
            idx = cur + 4'(i);
            if (!found && m[idx]) begin
                res   = idx;
                found = 1'b1;
            end else begin
                found = found;
            end
        end
        return res;
    endfunction

    // Bank write port.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < 16; k++) begin
                bank_q[k] <= '0;
            end
        end else if (wr_en) begin
            bank_q[wr_addr] <= wr_data;
        end
    end

    // Pack the bank for the downstream mux.
    always_comb begin
        q_flat = '0;
        for (int k = 0; k < 16; k++) begin
            q_flat[k*N +: N] = bank_q[k];
        end
    end

    assign next_s = next_chan(mask, sel_q);

    // Sequencer next-state logic; stop has priority over both start and advance.
    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        cnt_d   = cnt_q;
        wrap_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                cnt_d = 8'd0;
                if (start && !stop && (mask != 16'd0)) begin
                    state_d = ST_SCAN;
                    sel_d   = lowest_chan(mask);
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SCAN: begin
                if (stop) begin
                    state_d = ST_IDLE;
                    cnt_d   = 8'd0;
                end else if (cnt_q == DWELL_LAST) begin
                    cnt_d = 8'd0;
                    if (mask == 16'd0) begin
                        state_d = ST_IDLE;
                    end else if (next_s <= sel_q) begin
                        wrap_d = 1'b1;
`ifdef SCAN_ONESHOT_EN
                        state_d = ST_IDLE;
`else
                        sel_d = next_s;
`endif
                    end else begin
                        sel_d = next_s;
                    end
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = 8'd0;
            end
        endcase
        busy_d  = (state_d == ST_SCAN);
        valid_d = (state_d == ST_SCAN);
    end

    // Sequencer state and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            sel_q   <= 4'd0;
            cnt_q   <= 8'd0;
            wrap_q  <= 1'b0;
            busy_q  <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            cnt_q   <= cnt_d;
            wrap_q  <= wrap_d;
            busy_q  <= busy_d;
            valid_q <= valid_d;
        end
    end

    assign sel       = sel_q;
    assign sel_valid = valid_q;
    assign busy      = busy_q;
    assign wrap      = wrap_q;

endmodule

// File: tb/tb_reg_bank_scanner.sv
// Directed self-checking bench for reg_bank_scanner; expectations are hand-derived per cycle.
module tb_reg_bank_scanner;

`ifdef SCAN_ONESHOT_EN
    localparam int DW = 2;
`else
    localparam int DW = 4;
`endif
    localparam int N = 8;

    logic            clk = 1'b0;
    logic            rst, wr_en, start, stop;
    logic [3:0]      wr_addr;
    logic [N-1:0]    wr_data;
    logic [15:0]     mask;
    logic [16*N-1:0] q_flat;
    logic [3:0]      sel;
    logic            sel_valid, busy, wrap;

    int n_vec = 0;
    int n_err = 0;
    logic [16*N-1:0] exp_bank;

    reg_bank_scanner #(.N(N), .DWELL(DW)) dut (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .start(start), .stop(stop), .mask(mask), .q_flat(q_flat), .sel(sel),
        .sel_valid(sel_valid), .busy(busy), .wrap(wrap)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; wr_en = 1'b0; start = 1'b0; stop = 1'b0;
        wr_addr = 4'd0; wr_data = '0; mask = 16'd0;
        tick(); tick();
        rst = 1'b0;
        exp_bank = '0;
        for (int c = 0; c < 10; c++) begin
            tick();
            n_vec++;
            if ({q_flat, sel, sel_valid, busy, wrap} !== {exp_bank, 4'd0, 3'b000}) begin
                n_err++;
                $display("FAIL reset_idle c=%0d got sel=%0d v=%b b=%b w=%b q=%h want all zero",
                         c, sel, sel_valid, busy, wrap, q_flat);
            end
        end
    endtask

    task automatic test_write();
        for (int k = 0; k < 16; k++) begin
            wr_en = 1'b1; wr_addr = 4'(k); wr_data = 8'hA0 + 8'(k);
            tick();
            exp_bank[k*N +: N] = 8'hA0 + 8'(k);
            n_vec++;
            if (q_flat !== exp_bank) begin
                n_err++;
                $display("FAIL write k=%0d got %h want %h", k, q_flat, exp_bank);
            end
        end
        wr_en = 1'b0;
    endtask

`ifndef SCAN_ONESHOT_EN
    task automatic test_scan();
        logic [3:0] seq [3];
        logic [3:0] es;
        logic       ew;
        seq[0] = 4'd0; seq[1] = 4'd1; seq[2] = 4'd4;
        mask = 16'h0013; start = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 0; c < 24; c++) begin
            if (c > 0) tick();
            es = seq[(c / 4) % 3];
            ew = (c == 12);
            n_vec++;
            if ({sel, sel_valid, busy, wrap} !== {es, 1'b1, 1'b1, ew}) begin
                n_err++;
                $display("FAIL scan c=%0d got sel=%0d v=%b b=%b w=%b want sel=%0d v=1 b=1 w=%b",
                         c, sel, sel_valid, busy, wrap, es, ew);
            end
            if (c == 6) begin
                n_vec++;
                if (q_flat !== exp_bank) begin
                    n_err++;
                    $display("FAIL scan_write got %h want %h", q_flat, exp_bank);
                end
                wr_en = 1'b0;
            end
            if (c == 5) begin
                wr_en = 1'b1; wr_addr = 4'd5; wr_data = 8'h55;
                exp_bank[5*N +: N] = 8'h55;
            end
        end
        stop = 1'b1;
        tick();
        stop = 1'b0;
        n_vec++;
        if ({busy, sel_valid, wrap} !== 3'b000) begin
            n_err++;
            $display("FAIL scan_stop got b=%b v=%b w=%b want 000", busy, sel_valid, wrap);
        end
    endtask

    task automatic test_single_and_empty();
        logic ew;
        mask = 16'h8000; start = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 0; c < 12; c++) begin
            if (c > 0) tick();
            ew = (c == 4) || (c == 8);
            n_vec++;
            if ({sel, sel_valid, busy, wrap} !== {4'd15, 1'b1, 1'b1, ew}) begin
                n_err++;
                $display("FAIL single c=%0d got sel=%0d v=%b b=%b w=%b want sel=15 v=1 b=1 w=%b",
                         c, sel, sel_valid, busy, wrap, ew);
            end
            if (c == 9) mask = 16'd0;
        end
        tick();
        n_vec++;
        if ({sel, sel_valid, busy, wrap} !== {4'd15, 3'b000}) begin
            n_err++;
            $display("FAIL empty_mask got sel=%0d v=%b b=%b w=%b want sel=15 000",
                     sel, sel_valid, busy, wrap);
        end
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 0; c < 3; c++) begin
            if (c > 0) tick();
            n_vec++;
            if ({sel, sel_valid, busy, wrap} !== {4'd15, 3'b000}) begin
                n_err++;
                $display("FAIL start_empty c=%0d got sel=%0d v=%b b=%b w=%b want sel=15 000",
                         c, sel, sel_valid, busy, wrap);
            end
        end
    endtask

    task automatic test_stop_priority();
        mask = 16'h0013; start = 1'b1; stop = 1'b1;
        tick();
        start = 1'b0; stop = 1'b0;
        n_vec++;
        if ({busy, sel_valid} !== 2'b00) begin
            n_err++;
            $display("FAIL start_stop_idle got b=%b v=%b want 00", busy, sel_valid);
        end
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 1; c <= 5; c++) tick();
        n_vec++;
        if ({sel, busy} !== {4'd1, 1'b1}) begin
            n_err++;
            $display("FAIL pre_stop got sel=%0d b=%b want sel=1 b=1", sel, busy);
        end
        stop = 1'b1;
        tick();
        stop = 1'b0;
        n_vec++;
        if ({sel, sel_valid, busy, wrap} !== {4'd1, 3'b000}) begin
            n_err++;
            $display("FAIL stop_mid got sel=%0d v=%b b=%b w=%b want sel=1 000",
                     sel, sel_valid, busy, wrap);
        end
        start = 1'b1;
        tick();
        start = 1'b0;
        tick(); tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        exp_bank = '0;
        n_vec++;
        if ({q_flat, sel, sel_valid, busy, wrap} !== {exp_bank, 4'd0, 3'b000}) begin
            n_err++;
            $display("FAIL rst_mid got sel=%0d v=%b b=%b w=%b q=%h want all zero",
                     sel, sel_valid, busy, wrap, q_flat);
        end
    endtask
`else
    task automatic test_oneshot();
        logic [3:0] es [8];
        logic       eb [8];
        logic       ew [8];
        for (int c = 0; c < 8; c++) begin
            es[c] = (c < 2) ? 4'd0 : 4'd2;
            eb[c] = (c < 4);
            ew[c] = (c == 4);
        end
        mask = 16'h0005; start = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 0; c < 8; c++) begin
            if (c > 0) tick();
            n_vec++;
            if ({sel, sel_valid, busy, wrap} !== {es[c], eb[c], eb[c], ew[c]}) begin
                n_err++;
                $display("FAIL oneshot c=%0d got sel=%0d v=%b b=%b w=%b want sel=%0d v=%b b=%b w=%b",
                         c, sel, sel_valid, busy, wrap, es[c], eb[c], eb[c], ew[c]);
            end
        end
    endtask
`endif

    initial begin
        test_reset();
        test_write();
`ifndef SCAN_ONESHOT_EN
        test_scan();
        test_single_and_empty();
        test_stop_priority();
`else
        test_oneshot();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
